popcount_rr_sched: RTL and testbench
====================================

# popcount_rr_sched

Round-robin scheduler that shares one `count_16_bit` population-count datapath among four requesters. Each requester presents a 16-bit word with a valid/ready handshake. The scheduler grants one requester per cycle and feeds its word to the shared counter. It returns the registered 5-bit count, tagged with the requester ID, on a single valid/ready result port. It sits between the requester-side logic and any consumer of bit-count results, and is the only instantiator of `count_16_bit`.

## Interface
- `ACC_W`, 12, width of each per-requester running-total accumulator (used only with `POPCNT_ACCUM_EN`)
- `CLK` in 1: clock, rising edge
- `RST` in 1: reset, synchronous, active-high
- `REQ_VALID` in 4: bit i = requester i has a word pending
- `REQ_DATA` in 64: requester i word at `[16i+15:16i]`
- `REQ_READY` out 4: one-hot grant; bit i high = requester i's word is accepted this cycle when `REQ_VALID[i]` is high
- `RES_VALID` out 1: result register holds a valid result
- `RES_READY` in 1: consumer accepts the result
- `RES_COUNT` out 5: number of ones in the granted word, 0..16
- `RES_ID` out 2: index of the requester that produced `RES_COUNT`
- `ACC_CLR` in 4: bit i clears accumulator i
- `ACC_TOTAL` out 4*ACC_W: accumulator i at `[ACC_W*i+ACC_W-1:ACC_W*i]`

## Operation
- Two-state FSM on the result slot:
  - EMPTY: `RES_VALID`=0.
  - FULL: `RES_VALID`=1.
- Slot is free when state is EMPTY, or when FULL with `RES_READY`=1 (drain and refill in the same cycle).
- Arbitration:
  - Combinational round-robin over `REQ_VALID`, searching from index `LAST+1` mod 4 upward.
  - `LAST` is the 2-bit index of the most recently granted requester.
  - `REQ_READY` is one-hot on the winner only when the slot is free and at least one `REQ_VALID` is high; otherwise it is all zero.
  - `REQ_READY` never asserts for a requester with `REQ_VALID`=0.
- On grant g:
  - Winner's word is routed through the mux into `count_16_bit`.
  - At the next edge, `RES_COUNT` takes the count, `RES_ID` takes g, `LAST` takes g, and state becomes FULL.
- FULL with `RES_READY`=1 and no grant: next state EMPTY. `RES_COUNT` and `RES_ID` hold their last values.
- FULL with `RES_READY`=0: all outputs hold and `REQ_READY` is 0, so no requester loses data (backpressure).
- Requesters must hold `REQ_DATA` stable while `REQ_VALID` is high and not yet granted; the block does not check this.

## Timing
- Reset values:
  - State EMPTY.
  - `RES_VALID`=0, `RES_COUNT`=0, `RES_ID`=0.
  - `LAST`=3, so requester 0 has first priority.
  - All accumulators 0.
  - `REQ_READY`=0 during the reset cycle.
- Latency: grant at cycle N gives `RES_VALID`=1 with the data at cycle N+1.
- Throughput: one result per cycle while `RES_READY` stays high.
- Fairness: with all four requesters continuously valid, grants cycle 0,1,2,3,0,…; no requester waits more than 3 grants.
- `RST` asserted mid-operation: everything returns to reset values at that edge and any held result is discarded. `REQ_READY` is forced to 0 while `RST`=1.

## Configuration
- `POPCNT_ACCUM_EN` defined:
  - Accumulator i adds the granted count at the grant edge when g=i.
  - Accumulators saturate at 2^ACC_W−1.
  - `ACC_CLR[i]` zeroes accumulator i at the next edge.
  - Clear and grant to i in the same cycle: accumulator i takes the new count (clear, then add).
- `POPCNT_ACCUM_EN` not defined:
  - No accumulator registers are built.
  - `ACC_TOTAL` is tied to 0 and `ACC_CLR` is ignored.
  - All other behaviour is identical.

## Test plan
- Reset, then only requester 2 valid with `0xFFFF`, `RES_READY`=1:
  - `REQ_READY`=`0100` in the first cycle.
  - Next cycle: `RES_VALID`=1, `RES_COUNT`=16, `RES_ID`=2.
- All four requesters valid (words `0x0000`, `0xFFF0`, `0x7FFF`, `0x0001`), `RES_READY`=1:
  - Results stream back-to-back with IDs 0,1,2,3,0 and counts 0,12,15,1,0.
- Backpressure: hold `RES_READY`=0 for 3 cycles after a result with requesters 0 and 1 valid:
  - `RES_COUNT` and `RES_ID` stay stable and `REQ_READY` stays 0.
  - After release, the next grant goes to `LAST+1`.
- Assert `RST` in the cycle after a grant while `RES_VALID`=1:
  - Next cycle `RES_VALID`=0 and `RES_COUNT`=0.
  - First grant after reset goes to requester 0.
- With `POPCNT_ACCUM_EN` and `ACC_W`=5, grant requester 1 three times with `0xFFFF`:
  - `ACC_TOTAL[1]` reads 16, then 31 (saturated), then 31.
  - `ACC_CLR[1]` asserted together with a `0x000F` grant leaves 4.
- Without `POPCNT_ACCUM_EN`, rerun the accumulator scenario:
  - `ACC_TOTAL` reads 0 throughout.
  - `RES_*` traffic is identical to the run with the macro defined.

Source files
------------

// File: rtl/popcount_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : popcount_rr_sched
// Purpose  : Round-robin scheduler sharing one count_16_bit population-count
//            datapath among four valid/ready requesters. The count of the
//            granted word is registered into a single result slot, tagged
//            with the requester index.
// Ports    : CLK, RST        - clock (rising edge), synchronous active-high reset
//            REQ_VALID[3:0]  - per-requester word pending
//            REQ_DATA[63:0]  - requester i word at [16i+15:16i]
//            REQ_READY[3:0]  - one-hot grant (word accepted this cycle)
//            RES_VALID       - result slot holds a result
//            RES_READY       - consumer accepts the result
//            RES_COUNT[4:0]  - number of ones in the granted word
//            RES_ID[1:0]     - requester that produced RES_COUNT
//            ACC_CLR[3:0]    - per-requester accumulator clear
//            ACC_TOTAL       - per-requester saturating running totals
// Config   : `define POPCNT_ACCUM_EN builds the ACC_W-bit accumulators;
//            otherwise ACC_TOTAL is tied to zero and ACC_CLR is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module popcount_rr_sched #(
  parameter int ACC_W = 12
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [3:0]         REQ_VALID,
  input  logic [63:0]        REQ_DATA,
  output logic [3:0]         REQ_READY,
  output logic               RES_VALID,
  input  logic               RES_READY,
  output logic [4:0]         RES_COUNT,
  output logic [1:0]         RES_ID,
  input  logic [3:0]         ACC_CLR,
  output logic [4*ACC_W-1:0] ACC_TOTAL
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [1:0]  last_q, last_d;
  logic [4:0]  count_q, count_d;
  logic [1:0]  id_q, id_d;

  logic        slot_free;
  logic        any_valid;
  logic [1:0]  grant_idx;
  logic [1:0]  cand;
  logic        grant;
  logic [15:0] grant_word;
  logic [4:0]  grant_count;

  // The slot can take a new result when empty, or when the held result is
  // being drained this very cycle.
  assign slot_free = (state_q == ST_EMPTY) || RES_READY;
  assign any_valid = |REQ_VALID;

  // Search starts one past the last winner and wraps, so a continuously
  // valid requester waits at most three grants.
  always_comb begin
    grant_idx = last_q + 2'd1;
    cand      = last_q + 2'd1;
    for (int k = 4; k >= 1; k--) begin
      cand = last_q + 2'(k);
      if (REQ_VALID[cand]) begin
        grant_idx = cand;
      end
    end
  end

  assign grant = !RST && slot_free && any_valid;

  always_comb begin
    REQ_READY = 4'b0000;
    if (grant) begin
      REQ_READY[grant_idx] = 1'b1;
    end
  end

  assign grant_word = REQ_DATA[16*grant_idx +: 16];

  count_16_bit u_count (
    .data_i  (grant_word),
    .count_o (grant_count)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    count_d = count_q;
    id_d    = id_q;
    if (grant) begin
      state_d = ST_FULL;
      last_d  = grant_idx;
      count_d = grant_count;
      id_d    = grant_idx;
    end else if ((state_q == ST_FULL) && RES_READY) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_EMPTY;
      last_q  <= 2'd3;
      count_q <= 5'd0;
      id_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      count_q <= count_d;
      id_q    <= id_d;
    end
  end

  assign RES_VALID = (state_q == ST_FULL);
  assign RES_COUNT = count_q;
  assign RES_ID    = id_q;

`ifdef POPCNT_ACCUM_EN
  for (genvar gi = 0; gi < 4; gi++) begin : g_acc
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W:0]   sum;

    // Clear takes effect first so a same-cycle grant lands on a zeroed total.
    always_comb begin
      sum = ACC_CLR[gi] ? '0 : {1'b0, acc_q};
      if (grant && (grant_idx == 2'(gi))) begin
        sum = sum + {{(ACC_W-4){1'b0}}, grant_count};
      end
      acc_d = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        acc_q <= '0;
      end else begin
        acc_q <= acc_d;
      end
    end

    assign ACC_TOTAL[ACC_W*gi +: ACC_W] = acc_q;
  end
`else
  logic unused_acc_clr;
  assign unused_acc_clr = ^ACC_CLR;
  assign ACC_TOTAL      = '0;
`endif

endmodule

// ============================================================================
// Module   : count_16_bit
// Purpose  : Combinational population count of a 16-bit word.
// Ports    : data_i[15:0] - word to count
//            count_o[4:0] - number of set bits, 0..16
// Revision : 1.0 - initial release
// ============================================================================
module count_16_bit (
  input  logic [15:0] data_i,
  output logic [4:0]  count_o
);

  always_comb begin
    count_o = 5'd0;
    for (int b = 0; b < 16; b++) begin
      count_o = count_o + {4'd0, data_i[b]};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_popcount_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_popcount_rr_sched
// Purpose  : Directed self-checking bench for popcount_rr_sched (ACC_W = 5).
// Revision : 1.0 - initial release
// ============================================================================
module tb_popcount_rr_sched;

  localparam int ACC_W = 5;

  logic               CLK;
  logic               RST;
  logic [3:0]         REQ_VALID;
  logic [63:0]        REQ_DATA;
  logic [3:0]         REQ_READY;
  logic               RES_VALID;
  logic               RES_READY;
  logic [4:0]         RES_COUNT;
  logic [1:0]         RES_ID;
  logic [3:0]         ACC_CLR;
  logic [4*ACC_W-1:0] ACC_TOTAL;

  logic [15:0] word [4];
  int          n_checks;
  int          n_pass;

  assign REQ_DATA = {word[3], word[2], word[1], word[0]};

  popcount_rr_sched #(.ACC_W(ACC_W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_DATA  (REQ_DATA),
    .REQ_READY (REQ_READY),
    .RES_VALID (RES_VALID),
    .RES_READY (RES_READY),
    .RES_COUNT (RES_COUNT),
    .RES_ID    (RES_ID),
    .ACC_CLR   (ACC_CLR),
    .ACC_TOTAL (ACC_TOTAL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Expected accumulator value: only meaningful when the feature is built.
  function automatic logic [31:0] acc_exp(input logic [31:0] v);
`ifdef POPCNT_ACCUM_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  logic [4:0] stream_cnt [4];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    RST = 1'b1;
    REQ_VALID = 4'b0000;
    RES_READY = 1'b0;
    ACC_CLR = 4'b0000;
    word[0] = 16'h0000; word[1] = 16'h0000; word[2] = 16'h0000; word[3] = 16'h0000;
    stream_cnt[0] = 5'd0; stream_cnt[1] = 5'd12; stream_cnt[2] = 5'd15; stream_cnt[3] = 5'd1;

    step();
    step();
    // Reset state, with requests present to show REQ_READY is forced low.
    REQ_VALID = 4'b1111;
    #1;
    check("rst_req_ready", 32'(REQ_READY), 32'h0);
    check("rst_res_valid", 32'(RES_VALID), 32'd0);
    check("rst_res_count", 32'(RES_COUNT), 32'd0);
    check("rst_res_id",    32'(RES_ID),    32'd0);
    check("rst_acc_total", 32'(ACC_TOTAL), 32'd0);

    // Single requester 2 with all ones.
    RST = 1'b0;
    REQ_VALID = 4'b0100;
    word[2] = 16'hFFFF;
    RES_READY = 1'b1;
    #1;
    check("r2_req_ready", 32'(REQ_READY), 32'h4);
    step();
    REQ_VALID = 4'b0000;
    check("r2_res_valid", 32'(RES_VALID), 32'd1);
    check("r2_res_count", 32'(RES_COUNT), 32'd16);
    check("r2_res_id",    32'(RES_ID),    32'd2);
    step();
    check("r2_drain_valid", 32'(RES_VALID), 32'd0);
    check("r2_hold_count",  32'(RES_COUNT), 32'd16);

    // Reset pulse restores requester 0 priority, then stream all four.
    RST = 1'b1;
    step();
    RST = 1'b0;
    word[0] = 16'h0000; word[1] = 16'hFFF0; word[2] = 16'h7FFF; word[3] = 16'h0001;
    REQ_VALID = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("stream_ready_%0d", k), 32'(REQ_READY), 32'(4'b0001 << (k % 4)));
      step();
      check($sformatf("stream_valid_%0d", k), 32'(RES_VALID), 32'd1);
      check($sformatf("stream_id_%0d", k),    32'(RES_ID),    32'(k % 4));
      check($sformatf("stream_cnt_%0d", k),   32'(RES_COUNT), 32'(stream_cnt[k % 4]));
    end

    // Backpressure: result (id 1, count 12) must hold, no grants.
    REQ_VALID = 4'b0011;
    RES_READY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp_ready_%0d", k), 32'(REQ_READY), 32'h0);
      check($sformatf("bp_valid_%0d", k), 32'(RES_VALID), 32'd1);
      check($sformatf("bp_id_%0d", k),    32'(RES_ID),    32'd1);
      check($sformatf("bp_cnt_%0d", k),   32'(RES_COUNT), 32'd12);
      step();
    end
    // Release: search starts at 2, wraps to 0.
    RES_READY = 1'b1;
    #1;
    check("bp_rel_ready", 32'(REQ_READY), 32'h1);
    step();
    check("bp_rel_id",  32'(RES_ID),    32'd0);
    check("bp_rel_cnt", 32'(RES_COUNT), 32'd0);
    #1;
    check("bp_next_ready", 32'(REQ_READY), 32'h2);
    step();
    check("bp_next_id",  32'(RES_ID),    32'd1);
    check("bp_next_cnt", 32'(RES_COUNT), 32'd12);

    // Reset while a result is held; LAST was 1, so requester 2 would win
    // without the reset.
    REQ_VALID = 4'b1111;
    RST = 1'b1;
    #1;
    check("mid_rst_ready", 32'(REQ_READY), 32'h0);
    step();
    RST = 1'b0;
    check("mid_rst_valid", 32'(RES_VALID), 32'd0);
    check("mid_rst_count", 32'(RES_COUNT), 32'd0);
    check("mid_rst_id",    32'(RES_ID),    32'd0);
    #1;
    check("post_rst_ready", 32'(REQ_READY), 32'h1);
    step();
    check("post_rst_valid", 32'(RES_VALID), 32'd1);
    check("post_rst_id",    32'(RES_ID),    32'd0);

    // Accumulator: requester 1 with all ones three times, saturating at 31.
    REQ_VALID = 4'b0010;
    word[1] = 16'hFFFF;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("acc_ready_%0d", k), 32'(REQ_READY), 32'h2);
      step();
      check($sformatf("acc_cnt_%0d", k), 32'(RES_COUNT), 32'd16);
      check($sformatf("acc_id_%0d", k),  32'(RES_ID),    32'd1);
      check($sformatf("acc_tot_%0d", k), 32'(ACC_TOTAL[ACC_W*1 +: ACC_W]),
            acc_exp((k == 0) ? 32'd16 : 32'd31));
    end
    // Clear together with a grant of 0x000F leaves 4.
    word[1] = 16'h000F;
    ACC_CLR = 4'b0010;
    step();
    check("acc_clr_cnt", 32'(RES_COUNT), 32'd4);
    check("acc_clr_tot", 32'(ACC_TOTAL[ACC_W*1 +: ACC_W]), acc_exp(32'd4));
    check("acc_other",   32'(ACC_TOTAL[ACC_W*0 +: ACC_W]), 32'd0);
    // No grant: total holds, slot drains.
    ACC_CLR = 4'b0000;
    REQ_VALID = 4'b0000;
    step();
    check("acc_hold_tot", 32'(ACC_TOTAL[ACC_W*1 +: ACC_W]), acc_exp(32'd4));
    check("acc_drain",    32'(RES_VALID), 32'd0);
    // Clear alone zeroes.
    ACC_CLR = 4'b0010;
    step();
    ACC_CLR = 4'b0000;
    check("acc_clr_only", 32'(ACC_TOTAL[ACC_W*1 +: ACC_W]), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
